// File: rtl/serdesphy_tx_src_mux.sv
// Transmit source multiplexer: picks one byte-stream source (fixed or round-robin)
// or an idle pattern, and registers the chosen beat into a single output slot.
module serdesphy_tx_src_mux #(
  parameter int                 DATA_W       = 8,
  parameter int                 NUM_SRC      = 4,
  parameter int                 SEL_W        = $clog2(NUM_SRC),
  parameter logic [DATA_W-1:0]  IDLE_PATTERN = {DATA_W{1'b0}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      tx_idle,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          src_sel,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [DATA_W-1:0]         mux_data,
  output logic                      mux_valid,
  input  logic                      mux_ready,
  output logic [SEL_W-1:0]          mux_src,
  output logic                      mux_is_idle,
  output logic                      sel_err
);

  logic              r_mux_valid;
  logic [DATA_W-1:0] r_mux_data;
  logic [SEL_W-1:0]  r_mux_src;
  logic              r_mux_is_idle;
  logic              r_sel_err;
  logic [SEL_W-1:0]  r_rr_ptr;

  logic              w_slot_free;
  logic              w_sel_bad;
  logic              w_fix_hit;
  logic              w_rr_hit;
  logic [SEL_W-1:0]  w_rr_idx;
  logic [SEL_W:0]    w_rr_sum;
  logic              w_grant_vld;
  logic [SEL_W-1:0]  w_grant_idx;
  logic [DATA_W-1:0] w_grant_data;
  logic              w_take;

  assign w_slot_free = !r_mux_valid || mux_ready;

  // Out-of-range select only possible when NUM_SRC is not a power of two.
  generate
    if (NUM_SRC < (1 << SEL_W)) begin : g_sel_chk
      assign w_sel_bad = int'(src_sel) >= NUM_SRC;
    end else begin : g_sel_full
      assign w_sel_bad = 1'b0;
    end
  endgenerate

  always_comb begin
    w_fix_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_sel == SEL_W'(i) && src_valid[i]) w_fix_hit = 1'b1;
    end
  end

  // Scan from farthest to nearest offset so the nearest valid source after rr_ptr wins.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    w_rr_sum = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      w_rr_sum = {1'b0, r_rr_ptr} + (SEL_W+1)'(k);
      if (w_rr_sum >= (SEL_W+1)'(NUM_SRC)) w_rr_sum = w_rr_sum - (SEL_W+1)'(NUM_SRC);
      if (src_valid[w_rr_sum[SEL_W-1:0]]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = w_rr_sum[SEL_W-1:0];
      end
    end
  end

  assign w_grant_vld = mode ? w_rr_hit : (w_fix_hit && !w_sel_bad);
  assign w_grant_idx = mode ? w_rr_idx : src_sel;
  assign w_take      = !rst && enable && !tx_idle && w_grant_vld && w_slot_free;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_ready
      assign src_ready[gi] = w_take && (w_grant_idx == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    w_grant_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_grant_idx == SEL_W'(i)) w_grant_data = src_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mux_valid   <= 1'b0;
      r_mux_data    <= '0;
      r_mux_src     <= '0;
      r_mux_is_idle <= 1'b0;
      r_sel_err     <= 1'b0;
      r_rr_ptr      <= SEL_W'(NUM_SRC - 1);
    end else if (!enable) begin
      // Flush: pending beat is dropped, arbitration history and error flag survive.
      r_mux_valid   <= 1'b0;
      r_mux_data    <= '0;
      r_mux_src     <= '0;
      r_mux_is_idle <= 1'b0;
    end else begin
      if (!tx_idle && !mode && w_sel_bad) r_sel_err <= 1'b1;
      if (w_slot_free) begin
        if (tx_idle) begin
          r_mux_valid   <= 1'b1;
          r_mux_data    <= IDLE_PATTERN;
          r_mux_src     <= '0;
          r_mux_is_idle <= 1'b1;
        end else if (w_take) begin
          r_mux_valid   <= 1'b1;
          r_mux_data    <= w_grant_data;
          r_mux_src     <= w_grant_idx;
          r_mux_is_idle <= 1'b0;
          if (mode) r_rr_ptr <= w_grant_idx;
        end else begin
          r_mux_valid   <= 1'b0;
        end
      end
    end
  end

  assign mux_valid   = r_mux_valid;
  assign mux_data    = r_mux_data;
  assign mux_src     = r_mux_src;
  assign mux_is_idle = r_mux_is_idle;
  assign sel_err     = r_sel_err;

endmodule

// File: tb/tb_serdesphy_tx_src_mux.sv
// Bench for serdesphy_tx_src_mux: per-cycle vector table plus scoreboarded streaming
// sequences on a 4-source instance, and a 3-source instance for the illegal select.
module tb_serdesphy_tx_src_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, tx_idle, mode, mux_ready;
  logic [1:0]  src_sel;
  logic [31:0] src_data;
  logic [3:0]  src_valid, src_ready;
  logic [7:0]  mux_data;
  logic        mux_valid, mux_is_idle, sel_err;
  logic [1:0]  mux_src;

  logic        en3, mode3, mrdy3;
  logic [1:0]  sel3;
  logic [23:0] data3;
  logic [2:0]  valid3, rdy3;
  logic [7:0]  md3;
  logic        mv3, mi3, err3;
  logic [1:0]  ms3;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  serdesphy_tx_src_mux #(.DATA_W(8), .NUM_SRC(4)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .tx_idle(tx_idle), .mode(mode),
    .src_sel(src_sel), .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .mux_data(mux_data), .mux_valid(mux_valid), .mux_ready(mux_ready), .mux_src(mux_src),
    .mux_is_idle(mux_is_idle), .sel_err(sel_err)
  );

  serdesphy_tx_src_mux #(.DATA_W(8), .NUM_SRC(3)) u_dut3 (
    .clk(clk), .rst(rst), .enable(en3), .tx_idle(1'b0), .mode(mode3),
    .src_sel(sel3), .src_data(data3), .src_valid(valid3), .src_ready(rdy3),
    .mux_data(md3), .mux_valid(mv3), .mux_ready(mrdy3), .mux_src(ms3),
    .mux_is_idle(mi3), .sel_err(err3)
  );

  // Source model: source i presents base[i] + number of beats it has handed over.
  logic [7:0] base [4];
  logic [7:0] cnt  [4];
  logic       hold_cnt;

  always_comb begin
    src_data = '0;
    for (int i = 0; i < 4; i++) src_data[i*8 +: 8] = base[i] + cnt[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) cnt[i] <= 8'h00;
      else if (!hold_cnt && src_valid[i] && src_ready[i]) cnt[i] <= cnt[i] + 8'h01;
    end
  end

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] data;
    logic       idle;
  } beat_t;

  beat_t exp_q[$];
  beat_t sb_exp, sb_act;
  logic  sb_en = 1'b0;

  always @(negedge clk) begin
    if (sb_en && mux_valid && mux_ready) begin
      sb_act = '{src: mux_src, data: mux_data, idle: mux_is_idle};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got src=%0d data=%02h idle=%0b, required no beat",
                 sb_act.src, sb_act.data, sb_act.idle);
      end else begin
        sb_exp = exp_q.pop_front();
        if (sb_act !== sb_exp) begin
          n_err++;
          $display("FAIL sb_beat: got src=%0d data=%02h idle=%0b, required src=%0d data=%02h idle=%0b",
                   sb_act.src, sb_act.data, sb_act.idle, sb_exp.src, sb_exp.data, sb_exp.idle);
        end else begin
          $display("beat src=%0d data=%02h idle=%0b ok", sb_act.src, sb_act.data, sb_act.idle);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] s, input logic [7:0] d, input logic idl);
    exp_q.push_back('{src: s, data: d, idle: idl});
  endtask

  task automatic do_reset();
    sb_en     = 1'b0;
    rst       = 1'b1;
    src_valid = 4'b0000;
    tx_idle   = 1'b0;
    mux_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain_and_check(input string name);
    src_valid = 4'b0000;
    tick();
    chk({name, "_drained"}, mux_valid, 0);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    sb_en = 1'b0;
  endtask

  typedef struct {
    logic       en, idle, md;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       mrdy;
    logic [3:0] exp_rdy;
    logic       exp_mv;
    logic       chk_d;
    logic [7:0] exp_d;
    logic [1:0] exp_s;
    logic       exp_i;
  } vec_t;

  vec_t tv[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // en idle mode sel valid mrdy | rdy mv chk data src idle   (bases 11,22,33,44)
    tv[0]  = '{1'b1, 1'b0, 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 8'h33, 2'd2, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 1'b0, 2'd2, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 8'h33, 2'd2, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 1'b1, 2'd2, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h11, 2'd0, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 1'b1, 2'd2, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 8'h22, 2'd1, 1'b0};
    tv[4]  = '{1'b1, 1'b1, 1'b1, 2'd2, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b1, 8'h00, 2'd0, 1'b1};
    tv[5]  = '{1'b1, 1'b0, 1'b1, 2'd2, 4'b0101, 1'b1, 4'b0100, 1'b1, 1'b1, 8'h33, 2'd2, 1'b0};
    tv[6]  = '{1'b1, 1'b0, 1'b1, 2'd2, 4'b0101, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h11, 2'd0, 1'b0};
    tv[7]  = '{1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 2'd1, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 2'd1, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
    tv[10] = '{1'b1, 1'b0, 1'b0, 2'd1, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 8'h22, 2'd1, 1'b0};
    tv[11] = '{1'b1, 1'b0, 1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 1'b1, 8'h22, 2'd1, 1'b0};
    tv[12] = '{1'b1, 1'b0, 1'b1, 2'd1, 4'b1100, 1'b1, 4'b0100, 1'b1, 1'b1, 8'h33, 2'd2, 1'b0};

    base[0] = 8'h11; base[1] = 8'h22; base[2] = 8'h33; base[3] = 8'h44;
    hold_cnt = 1'b1;
    en3 = 1'b0; mode3 = 1'b0; sel3 = 2'd0; valid3 = 3'b000; mrdy3 = 1'b1; data3 = 24'hC3B2A1;

    // Reset state: src_ready must stay low while rst is high even with everything else enabling it.
    rst = 1'b1; enable = 1'b1; tx_idle = 1'b0; mode = 1'b1; src_sel = 2'd0;
    src_valid = 4'b1111; mux_ready = 1'b1;
    #1;
    chk("rst_src_ready", src_ready, 4'b0000);
    tick();
    chk("rst_mux_valid", mux_valid, 0);
    chk("rst_mux_data", mux_data, 8'h00);
    chk("rst_mux_src", mux_src, 0);
    chk("rst_mux_is_idle", mux_is_idle, 0);
    chk("rst_sel_err", sel_err, 0);
    do_reset();

    // Vector table, one row per clock cycle.
    for (int r = 0; r < 13; r++) begin
      enable = tv[r].en; tx_idle = tv[r].idle; mode = tv[r].md; src_sel = tv[r].sel;
      src_valid = tv[r].valid; mux_ready = tv[r].mrdy;
      #1;
      chk($sformatf("tv%0d_src_ready", r), src_ready, tv[r].exp_rdy);
      tick();
      chk($sformatf("tv%0d_mux_valid", r), mux_valid, tv[r].exp_mv);
      if (tv[r].chk_d) begin
        chk($sformatf("tv%0d_mux_data", r), mux_data, tv[r].exp_d);
        chk($sformatf("tv%0d_mux_src", r), mux_src, tv[r].exp_s);
        chk($sformatf("tv%0d_mux_is_idle", r), mux_is_idle, tv[r].exp_i);
      end
      $display("vector %0d rdy=%b mv=%0b data=%02h src=%0d", r, src_ready, mux_valid, mux_data, mux_src);
    end
    hold_cnt = 1'b0;

    // Reset mid-stream, then round-robin restarts at source 0.
    do_reset();
    enable = 1'b1; mode = 1'b0; src_sel = 2'd1; src_valid = 4'b1111; mux_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("midrst_pre_valid", mux_valid, 1);
    chk("midrst_pre_src", mux_src, 1);
    rst = 1'b1;
    #1;
    chk("midrst_src_ready", src_ready, 4'b0000);
    tick();
    chk("midrst_mux_valid", mux_valid, 0);
    chk("midrst_mux_data", mux_data, 8'h00);
    chk("midrst_sel_err", sel_err, 0);
    rst = 1'b0; mode = 1'b1;
    #1;
    chk("midrst_first_rr_grant", src_ready, 4'b0001);
    tick();
    chk("midrst_first_rr_src", mux_src, 0);

    // Fixed-mode streaming A0..AF from source 2.
    do_reset();
    base[2] = 8'hA0; mode = 1'b0; src_sel = 2'd2; enable = 1'b1; sb_en = 1'b1;
    for (int k = 0; k < 16; k++) push(2'd2, 8'hA0 + 8'(k), 1'b0);
    src_valid = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk($sformatf("fixed_ready_%0d", k), src_ready, 4'b0100);
      tick();
      chk($sformatf("fixed_valid_%0d", k), mux_valid, 1);
    end
    drain_and_check("fixed");

    // Backpressure on a 5C beat, then consume-and-reload on the same edge.
    do_reset();
    base[0] = 8'h5C; mode = 1'b0; src_sel = 2'd0; mux_ready = 1'b0; src_valid = 4'b0001; sb_en = 1'b1;
    push(2'd0, 8'h5C, 1'b0); push(2'd0, 8'h5D, 1'b0); push(2'd0, 8'h5E, 1'b0);
    #1;
    chk("bp_first_ready", src_ready, 4'b0001);
    tick();
    chk("bp_loaded", mux_data, 8'h5C);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_stall_ready_%0d", k), src_ready, 4'b0000);
      tick();
      chk($sformatf("bp_stall_data_%0d", k), mux_data, 8'h5C);
    end
    mux_ready = 1'b1;
    #1;
    chk("bp_release_ready", src_ready, 4'b0001);
    tick();
    chk("bp_reload_data", mux_data, 8'h5D);
    chk("bp_reload_valid", mux_valid, 1);
    tick();
    drain_and_check("bp");

    // Round-robin fairness over 1011, then source 1 drops out.
    do_reset();
    base[0] = 8'h00; base[1] = 8'h10; base[2] = 8'h20; base[3] = 8'h30;
    mode = 1'b1; mux_ready = 1'b1; sb_en = 1'b1;
    push(2'd0, 8'h00, 1'b0); push(2'd1, 8'h10, 1'b0); push(2'd3, 8'h30, 1'b0);
    push(2'd0, 8'h01, 1'b0); push(2'd1, 8'h11, 1'b0); push(2'd3, 8'h31, 1'b0);
    push(2'd0, 8'h02, 1'b0); push(2'd3, 8'h32, 1'b0); push(2'd0, 8'h03, 1'b0); push(2'd3, 8'h33, 1'b0);
    src_valid = 4'b1011;
    for (int k = 0; k < 10; k++) begin
      if (k == 6) src_valid = 4'b1001;
      tick();
      chk($sformatf("rr_no_stall_%0d", k), mux_valid, 1);
    end
    drain_and_check("rr");

    // Idle override during source 1 streaming.
    do_reset();
    base[1] = 8'h40; mode = 1'b1; mux_ready = 1'b1; sb_en = 1'b1;
    push(2'd1, 8'h40, 1'b0); push(2'd1, 8'h41, 1'b0); push(2'd1, 8'h42, 1'b0);
    for (int k = 0; k < 4; k++) push(2'd0, 8'h00, 1'b1);
    push(2'd1, 8'h43, 1'b0); push(2'd1, 8'h44, 1'b0); push(2'd1, 8'h45, 1'b0);
    src_valid = 4'b0010;
    for (int k = 0; k < 3; k++) tick();
    tx_idle = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("idle_ready_%0d", k), src_ready, 4'b0000);
      tick();
      chk($sformatf("idle_flag_%0d", k), mux_is_idle, 1);
    end
    tx_idle = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("idle_resume_ready_%0d", k), src_ready, 4'b0010);
      tick();
    end
    drain_and_check("idle");
    chk("main_sel_err_clear", sel_err, 0);

    // Illegal select on the 3-source instance, then enable drop with a beat pending.
    do_reset();
    en3 = 1'b1; mode3 = 1'b0; sel3 = 2'd3; valid3 = 3'b111; mrdy3 = 1'b1;
    #1;
    chk("bad_sel_ready", rdy3, 3'b000);
    tick();
    chk("bad_sel_err_set", err3, 1);
    chk("bad_sel_no_beat", mv3, 0);
    sel3 = 2'd0;
    #1;
    chk("good_sel_ready", rdy3, 3'b001);
    tick();
    chk("sel_err_sticky", err3, 1);
    chk("good_sel_data", md3, 8'hA1);
    mrdy3 = 1'b0;
    en3 = 1'b0;
    tick();
    chk("en_drop_valid", mv3, 0);
    chk("en_drop_data", md3, 8'h00);
    chk("en_drop_err_held", err3, 1);
    en3 = 1'b1; valid3 = 3'b000; mrdy3 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("en_drop_no_reappear_%0d", k), mv3, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/serdesphy_tx_src_mux.md
# serdesphy_tx_src_mux

Parametrised transmit source multiplexer with full-throughput valid/ready handshakes. It selects one of NUM_SRC byte-stream sources (FIFO, PRBS, test patterns, and so on) in either fixed-select or round-robin mode, or forces a configurable idle pattern. The selected beat is registered into a single output slot that feeds the Manchester encoder. Sustained throughput is one beat per cycle.

## Interface
Parameters:
- DATA_W, 8, beat width in bits
- NUM_SRC, 4, number of sources (2..16)
- SEL_W, $clog2(NUM_SRC), source index width
- IDLE_PATTERN, {DATA_W{1'b0}}, beat emitted while tx_idle is asserted

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  24 MHz clock
- rst  in  1  synchronous active-high reset
- enable  in  1  block enable; low flushes and holds the block
- tx_idle  in  1  force IDLE_PATTERN beats and accept nothing from sources
- mode  in  1  0 = fixed select via src_sel, 1 = round-robin over valid sources
- src_sel  in  SEL_W  source index used in fixed mode
- src_data  in  NUM_SRC*DATA_W  source i occupies bits [i*DATA_W +: DATA_W]
- src_valid  in  NUM_SRC  per-source valid
- src_ready  out  NUM_SRC  per-source ready; one-hot or zero
- mux_data  out  DATA_W  registered output beat
- mux_valid  out  1  output beat valid
- mux_ready  in  1  downstream ready
- mux_src  out  SEL_W  index of the source of the current beat; 0 for idle beats
- mux_is_idle  out  1  current beat is an IDLE_PATTERN beat
- sel_err  out  1  sticky flag: fixed mode was used with src_sel >= NUM_SRC

## Operation
- **Output slot.** There is one output register (data, src, is_idle, valid).
  - slot_free = !mux_valid || mux_ready.
  - The slot loads only when slot_free is high and a load candidate exists.
- **Load candidate priority, evaluated each cycle:**
  - enable = 0: no candidate.
  - enable = 1 and tx_idle = 1: an IDLE_PATTERN beat. It loads with no source handshake, so src_ready = 0.
  - mode = 0: grant goes to src_sel when src_sel < NUM_SRC and src_valid[src_sel] is high.
  - mode = 1: grant goes to the first i with src_valid[i] = 1, searching i = (rr_ptr+1) mod NUM_SRC upward and wrapping.
- **src_ready[i].** src_ready[i] = enable & !tx_idle & granted(i) & slot_free.
  - A transfer occurs when src_valid[i] and src_ready[i] are both high.
  - On a transfer the slot loads src_data[i], mux_src = i and mux_is_idle = 0.
- **Round-robin pointer.** rr_ptr (SEL_W bits) updates to i only on a source transfer in mode 1. It is unchanged by idle beats, by fixed-mode transfers and by stalls. rr_ptr resets to NUM_SRC-1, so source 0 has first priority.
- **No candidate.** If slot_free is high and there is no candidate, mux_valid goes to 0 on the next cycle.
- **Selection changes.** Changes to mode, src_sel or tx_idle affect only the next load. A beat already in the slot is never altered or dropped.
- **enable falling.** On the clock edge where enable = 0:
  - mux_valid is cleared and the pending beat is discarded.
  - mux_data, mux_src and mux_is_idle are zeroed.
  - rr_ptr is held and sel_err is held.
- **sel_err.** Set when enable = 1, tx_idle = 0, mode = 0 and src_sel >= NUM_SRC. It clears only on rst. While this condition holds, no source is granted.
- **Reset values.** On rst = 1, all of the following take effect on the next edge and apply mid-transfer too:
  - mux_valid = 0, mux_data = 0, mux_src = 0, mux_is_idle = 0
  - sel_err = 0, rr_ptr = NUM_SRC-1
  - src_ready is forced to 0 while rst is high.

## Timing
- src_ready is combinational from src_valid, mode, src_sel, tx_idle, enable, mux_valid, mux_ready and rr_ptr. It has no dependency on src_data.
- Latency is 1 cycle: a beat accepted at edge N is presented at mux_data/mux_valid after edge N.
- Throughput:
  - With mux_ready held high, one beat is transferred per cycle.
  - The slot is reloaded in the same cycle it is consumed, with no bubble.
- Stall: while mux_valid = 1 and mux_ready = 0:
  - mux_data, mux_src and mux_is_idle are stable.
  - All src_ready are 0.
- Consume and reload in the same cycle: when mux_valid & mux_ready and a candidate exists, the new beat replaces the old one at the same edge.
- tx_idle asserted with mux_ready = 1 produces a continuous IDLE_PATTERN stream starting on the cycle after assertion.
- tx_idle deasserted: source beats may load on that same cycle.

## Test plan
- **Reset mid-stream.** Stream source 1 with NUM_SRC=4, assert rst for 1 cycle with mux_valid=1 -> next cycle mux_valid=0, mux_data=0, src_ready=4'b0000, sel_err=0; after release, the first round-robin grant goes to source 0.
- **Fixed-mode streaming.** mode=0, src_sel=2, src_valid=4'b1111, mux_ready=1, source 2 supplies 8'hA0..8'hAF -> 16 consecutive beats A0..AF with mux_src=2, a 1-cycle latency and no gaps; src_ready=4'b0100 throughout.
- **Backpressure.** mux_ready=0 for 5 cycles while mux_valid=1 with mux_data=8'h5C -> mux_data holds 8'h5C and src_ready=0 for all 5 cycles; when mux_ready=1 returns, 8'h5C is consumed and the next beat loads on the same edge.
- **Round-robin fairness.** mode=1, src_valid=4'b1011 held, mux_ready=1 -> the mux_src sequence is 0,1,3,0,1,3…; dropping src_valid[1] mid-sequence leaves a sequence of 0,3,0,3 with no stall cycle.
- **Idle override.** With IDLE_PATTERN=8'h00, assert tx_idle for 4 cycles during FIFO streaming -> 4 beats of 8'h00 with mux_is_idle=1 and mux_src=0, src_ready=0, rr_ptr unchanged; streaming resumes with no lost or duplicated source beat.
- **Illegal select and enable drop.** NUM_SRC=3, mode=0, src_sel=3 -> sel_err goes to 1 and remains set after src_sel=0; dropping enable with a beat pending -> mux_valid=0 the next cycle and the pending beat never appears.
